// File: rtl/downcounter_if.sv
// Control/status bundle for the loadable down counter.
// The master drives load/d/en; the slave (the counter) returns count/zero/borrow/busy.
interface downcounter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             borrow;
  logic             busy;

  modport master (
    output load, d, en,
    input  count, zero, borrow, busy
  );

  modport slave (
    input  load, d, en,
    output count, zero, borrow, busy
  );
endinterface

// File: rtl/downcounter.sv
// Loadable down counter with terminal-count decode and one-cycle borrow on underflow.
// Macro DOWNCNT_AUTORELOAD_EN: when defined, underflow reloads the last loaded value; otherwise it wraps to all-ones.
module downcounter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  downcounter_if.slave  bus
);

`ifdef DOWNCNT_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             borrow_reg, borrow_next;
  logic [WIDTH-1:0] wrap_val;

  // Value taken on underflow: the reload register, or a free wrap to all-ones.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_wrap
    assign wrap_val[gi] = AUTORELOAD ? reload_reg[gi] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      borrow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      borrow_reg <= borrow_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    borrow_next = 1'b0;
    case (state_reg)
      IDLE: begin
        // en is deliberately ignored until the first load arms the counter.
        if (bus.load) begin
          count_next  = bus.d;
          reload_next = bus.d;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (bus.load) begin
          count_next  = bus.d;
          reload_next = bus.d;
        end else if (bus.en) begin
          if (count_reg == '0) begin
            count_next  = wrap_val;
            borrow_next = 1'b1;
          end else begin
            count_next = count_reg - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.count  = count_reg;
  assign bus.zero   = (count_reg == '0);
  assign bus.borrow = borrow_reg;
  assign bus.busy   = (state_reg == RUN);

endmodule

// File: tb/tb_downcounter.sv
// Self-checking bench for downcounter: vector table plus reset corner sequences,
// expectations queued at drive time and popped one cycle later.
module tb_downcounter;
  localparam int W = 4;

`ifdef DOWNCNT_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic         rst;
    logic         load;
    logic [W-1:0] d;
    logic         en;
    logic [W-1:0] count;
    logic         zero;
    logic         borrow;
    logic         busy;
    string        name;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];
  vec_t sbq[$];

  downcounter_if #(.WIDTH(W)) bus_i ();

  downcounter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic ld, input logic [W-1:0] dv, input logic e,
                     input logic [W-1:0] c, input logic b, input logic bz, input string nm);
    vec_t v;
    v.rst = r; v.load = ld; v.d = dv; v.en = e;
    v.count = c; v.zero = (c == '0); v.borrow = b; v.busy = bz; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic cmp1(input string nm, input string fld, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0d want=%0d", nm, fld, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the next edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst        = v.rst;
    bus_i.load = v.load;
    bus_i.d    = v.d;
    bus_i.en   = v.en;
    sbq.push_back(v);
    @(negedge clk);
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty", v.name);
    end else begin
      e = sbq.pop_front();
      cmp1(e.name, "count",  bus_i.count,       e.count);
      cmp1(e.name, "zero",   {3'b0, bus_i.zero},   {3'b0, e.zero});
      cmp1(e.name, "borrow", {3'b0, bus_i.borrow}, {3'b0, e.borrow});
      cmp1(e.name, "busy",   {3'b0, bus_i.busy},   {3'b0, e.busy});
      $display("txn %-10s rst=%b ld=%b d=%0d en=%b -> count=%0d zero=%b borrow=%b busy=%b",
               e.name, e.rst, e.load, e.d, e.en, bus_i.count, bus_i.zero, bus_i.borrow, bus_i.busy);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [W-1:0] dv, input logic e,
                      input logic [W-1:0] c, input logic b, input logic bz, input string nm);
    vec_t v;
    v.rst = r; v.load = ld; v.d = dv; v.en = e;
    v.count = c; v.zero = (c == '0); v.borrow = b; v.busy = bz; v.name = nm;
    apply(v);
  endtask

  initial begin
    logic [W-1:0] wrap13;
    logic [W-1:0] wrap0;
    total = 0;
    bad   = 0;
    wrap13 = AUTO ? 4'd13 : 4'd15;
    wrap0  = AUTO ? 4'd0  : 4'd15;
    rst = 1'b1; bus_i.load = 1'b0; bus_i.d = '0; bus_i.en = 1'b0;

    // Vector table: reset, idle en ignored, load/count-down, underflow, load-over-en, en toggling.
    add(1, 0, 0,  0, 0, 0, 0, "reset");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 0, "idle_en");
    add(0, 1, 13, 0, 13, 0, 1, "load13");
    for (int i = 12; i >= 0; i--) add(0, 0, 0, 1, 4'(i), 0, 1, "down");
    add(0, 0, 0,  1, wrap13, 1, 1, "underflow");
    add(0, 0, 0,  1, wrap13 - 4'd1, 0, 1, "post_uf");
    add(0, 1, 7,  0, 7, 0, 1, "load7");
    add(0, 1, 3,  1, 3, 0, 1, "load_en");
    add(0, 1, 5,  0, 5, 0, 1, "load5");
    add(0, 0, 0,  1, 4, 0, 1, "tog_en1");
    add(0, 0, 0,  0, 4, 0, 1, "tog_en0");
    add(0, 0, 0,  1, 3, 0, 1, "tog_en1");
    add(0, 0, 0,  0, 3, 0, 1, "tog_en0");
    add(0, 1, 0,  0, 0, 0, 1, "load0");
    add(0, 0, 0,  1, wrap0, 1, 1, "uf_from0");
    add(0, 0, 0,  0, wrap0, 0, 1, "hold");
    add(0, 1, 9,  1, 9, 0, 1, "load9");
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset while running from 2: everything clears, en then ignored in IDLE.
    step(0, 1, 3, 0, 3, 0, 1, "load3");
    step(0, 0, 0, 1, 2, 0, 1, "run2");
    step(1, 0, 0, 1, 0, 0, 0, "rst_mid");
    step(0, 0, 0, 1, 0, 0, 0, "idle_en2");
    step(0, 0, 0, 1, 0, 0, 0, "idle_en3");

    // Reset in the same cycle as an underflow step: the borrow must be dropped.
    step(0, 1, 0, 0, 0, 0, 1, "load0b");
    step(1, 0, 0, 1, 0, 0, 0, "rst_uf");
    step(0, 0, 0, 0, 0, 0, 0, "after_rst");

    // Load in the cycle right after an underflow clears borrow.
    step(0, 1, 1, 0, 1, 0, 1, "load1");
    step(0, 0, 0, 1, 0, 0, 1, "to0");
    step(0, 0, 0, 1, AUTO ? 4'd1 : 4'd15, 1, 1, "uf1");
    step(0, 1, 6, 1, 6, 0, 1, "reload6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
endmodule
